// File: rtl/div_32_seq_pkg.sv
// Shared definitions for the sequential 32-bit divider: state encoding,
// iteration count and the default quotient reported on divide-by-zero.
package div_32_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    SIGN = 2'd3
  } state_e;

  localparam int unsigned ITER_COUNT          = 32;
  localparam logic [31:0] DBZ_QUOTIENT_DEFAULT = 32'hFFFF_FFFF;

  // Index of the last CALC iteration, sized to the iteration counter.
  function automatic logic [4:0] last_iter();
    return 5'(ITER_COUNT - 1);
  endfunction

endpackage

// File: rtl/div_32_seq_add_32.sv
// add_32: 32-bit carry-lookahead adder built from eight 4-bit lookahead
// groups; each group produces its carry-out from group generate/propagate.
module add_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [32:0] c_s;

  // Generate/propagate terms and per-group lookahead carries.
  always_comb begin
    g_s    = a_i & b_i;
    p_s    = a_i ^ b_i;
    c_s    = 33'd0;
    c_s[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      c_s[4*k+1] = g_s[4*k]
                 | (p_s[4*k] & c_s[4*k]);
      c_s[4*k+2] = g_s[4*k+1]
                 | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+3] = g_s[4*k+2]
                 | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+4] = g_s[4*k+3]
                 | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | ((&p_s[4*k +: 4]) & c_s[4*k]);
    end
    sum_o  = p_s ^ c_s[31:0];
    cout_o = c_s[32];
  end

endmodule

// File: rtl/div_32_seq.sv
// div_32_seq: multi-cycle radix-2 non-restoring 32-bit divider (DIV).
// Quotient goes to LO, remainder to HI. Signed operation divides the
// magnitudes and fixes the signs at the end; all arithmetic goes through
// add_32 instances.
module div_32_seq
  import div_32_seq_pkg::*;
#(
  parameter logic [31:0] DBZ_QUOTIENT = DBZ_QUOTIENT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  state_e      state_q;
  logic [32:0] r_q;          // signed partial remainder
  logic [31:0] q_q;          // quotient bits / dividend shift register
  logic [31:0] d_q;          // divisor magnitude
  logic [4:0]  count_q;
  logic        neg_quo_q;    // quotient must be negated
  logic        neg_rem_q;    // remainder must be negated
  logic        dbz_pend_q;   // completing a divide-by-zero
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;

  // Iteration/correction adder signals
  logic        iter_sub_s;
  logic        iter_top_s;
  logic [31:0] iter_a_s;
  logic [31:0] iter_b_s;
  logic [31:0] iter_sum_s;
  logic        iter_cout_s;
  logic [32:0] iter_r_d;

  // Negation adder signals (operand magnitude in IDLE, result sign in SIGN)
  logic [31:0] neg_a_in_s;
  logic [31:0] neg_b_in_s;
  logic [31:0] neg_a_sum_s;
  logic [31:0] neg_b_sum_s;
  logic        neg_a_cout_unused;
  logic        neg_b_cout_unused;
  logic [31:0] dvd_mag_d;
  logic [31:0] dvs_mag_d;

  // Select adder operands: shifted remainder +/- D in CALC, R + D in FIX.
  always_comb begin
    iter_sub_s = 1'b0;
    iter_a_s   = r_q[31:0];
    iter_top_s = r_q[32];
    if (state_q == CALC) begin
      iter_sub_s = ~r_q[32];
      iter_a_s   = {r_q[30:0], q_q[31]};
      iter_top_s = r_q[31];
    end else begin
      iter_sub_s = 1'b0;
    end
    iter_b_s = iter_sub_s ? ~d_q : d_q;
    // 33rd bit of the result: operand top bits (D extended with 0, inverted
    // when subtracting) plus the adder carry-out.
    iter_r_d = {iter_top_s ^ iter_sub_s ^ iter_cout_s, iter_sum_s};
  end

  add_32 u_iter_add (
    .a_i    (iter_a_s),
    .b_i    (iter_b_s),
    .cin_i  (iter_sub_s),
    .sum_o  (iter_sum_s),
    .cout_o (iter_cout_s)
  );

  // Negators see raw operands in IDLE and the unsigned results otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      neg_a_in_s = dividend;
      neg_b_in_s = divisor;
    end else begin
      neg_a_in_s = q_q;
      neg_b_in_s = r_q[31:0];
    end
    dvd_mag_d = (signed_op && dividend[31]) ? neg_a_sum_s : dividend;
    dvs_mag_d = (signed_op && divisor[31])  ? neg_b_sum_s : divisor;
  end

  add_32 u_neg_a (
    .a_i    (32'd0),
    .b_i    (~neg_a_in_s),
    .cin_i  (1'b1),
    .sum_o  (neg_a_sum_s),
    .cout_o (neg_a_cout_unused)
  );

  add_32 u_neg_b (
    .a_i    (32'd0),
    .b_i    (~neg_b_in_s),
    .cin_i  (1'b1),
    .sum_o  (neg_b_sum_s),
    .cout_o (neg_b_cout_unused)
  );

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      r_q         <= 33'd0;
      q_q         <= 32'd0;
      d_q         <= 32'd0;
      count_q     <= 5'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_pend_q  <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            r_q     <= 33'd0;
            count_q <= 5'd0;
            state_q <= (divisor == 32'd0) ? SIGN : CALC;
            if (divisor == 32'd0) begin
              // Keep the raw dividend to report as the remainder.
              q_q        <= dividend;
              d_q        <= 32'd0;
              neg_quo_q  <= 1'b0;
              neg_rem_q  <= 1'b0;
              dbz_pend_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              q_q        <= dvd_mag_d;
              d_q        <= dvs_mag_d;
              neg_quo_q  <= signed_op & (dividend[31] ^ divisor[31]);
              neg_rem_q  <= signed_op & dividend[31];
              dbz_pend_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          r_q     <= iter_r_d;
          q_q     <= {q_q[30:0], ~iter_r_d[32]};
          count_q <= count_q + 5'd1;
          if (count_q == last_iter()) begin
            state_q <= FIX;
          end else begin
            state_q <= CALC;
          end
        end
        FIX: begin
          // Negative final remainder gets D added back.
          if (r_q[32]) begin
            r_q <= iter_r_d;
          end else begin
            r_q <= r_q;
          end
          state_q <= SIGN;
        end
        SIGN: begin
          if (dbz_pend_q) begin
            quotient_q  <= DBZ_QUOTIENT;
            remainder_q <= q_q;
            dbz_q       <= 1'b1;
          end else begin
            quotient_q  <= neg_quo_q ? neg_a_sum_s : q_q;
            remainder_q <= neg_rem_q ? neg_b_sum_s : r_q[31:0];
            dbz_q       <= 1'b0;
          end
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          dbz_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: fixed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for start-while-busy and mid-operation reset.
module tb_div_32_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  div_32_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint na;
    longint nb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      q = 32'(na / nb);
      r = 32'(na % nb);
      z = 1'b0;
    end
  endfunction

  // Issue one operation; inject>0 pulses a foreign start before edge E0+inject.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int inject,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat, output int busy_err);
    logic exp_busy;
    exp_busy = (b != 32'd0);
    busy_err = 0;
    lat      = 0;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = 1'($urandom);
    if (busy !== exp_busy || done !== 1'b0) busy_err++;
    for (int k = 1; k <= 60; k++) begin
      if (k == inject) begin
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        if (busy !== 1'b0) busy_err++;
        break;
      end else if (busy !== exp_busy) begin
        busy_err++;
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int inject,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez);
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    int          be;
    run_op(a, b, s, inject, q, r, z, lat, be);
    chk($sformatf("%s quotient", tag), q, eq);
    chk($sformatf("%s remainder", tag), r, er);
    chk($sformatf("%s div_by_zero", tag), 32'(z), 32'(ez));
    chk($sformatf("%s latency", tag), 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
    chk($sformatf("%s busy", tag), 32'(be), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, eq, er;
    logic        rs, ez;

    reset_n   = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    #1;
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // a, b, signed, quotient, remainder, div_by_zero
    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
    vecs.push_back('{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'd2,          1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'd2,          1'b1, 32'd0,          32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1});
    vecs.push_back('{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{32'hFFFF_FFF6,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF6,  1'b1});
    vecs.push_back('{32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'hFFFF_FFFE,  1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 0,
               vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 15);
        1:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 255);
        default: ra = $urandom;
      endcase
      rs = 1'($urandom);
      ref_div(ra, rb, rs, eq, er, ez);
      check_op($sformatf("rand%0d", i), ra, rb, rs, 0, eq, er, ez);
    end

    // Start pulse while busy is ignored.
    check_op("busy_start", 32'd1000, 32'd3, 1'b0, 5, 32'd333, 32'd1, 1'b0);

    // Reset in the middle of an operation clears outputs asynchronously.
    @(negedge clk);
    dividend  = 32'd123456;
    divisor   = 32'd789;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midreset quotient", quotient, 32'd0);
    chk("midreset remainder", remainder, 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    check_op("post_reset", 32'd50, 32'd5, 1'b0, 0, 32'd10, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
